// File: rtl/spi_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_sched
// Description : Round-robin scheduler for two requesters in front of an SPI
//               master. Handles retries on error, timeout abort, one response
//               per request.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sched #(
    parameter int WIDTH     = 11,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 64,
    parameter int GAP       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [1:0]       req_tgt,
    output logic [1:0]       ack,
    output logic             m_start,
    output logic [1:0]       m_sel,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_done,
    input  logic             m_err,
    input  logic [WIDTH-1:0] m_rdata,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_fail,
    output logic             rsp_tmo,
    output logic             busy
);

    localparam int c_tmr_w = $clog2(TIMEOUT);
    localparam int c_gap_w = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int c_rty_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [c_tmr_w-1:0] c_tmr_last  = c_tmr_w'(TIMEOUT - 1);
    localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(GAP - 1);
    localparam logic [c_rty_w-1:0] c_max_retry = c_rty_w'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_last, w_last_nxt;
    logic               r_id, w_id_nxt;
    logic [WIDTH-1:0]   r_frame, w_frame_nxt;
    logic               r_tgt, w_tgt_nxt;
    logic [c_rty_w-1:0] r_retry, w_retry_nxt;
    logic [c_tmr_w-1:0] r_timer, w_timer_nxt;
    logic [c_gap_w-1:0] r_gap, w_gap_nxt;
    logic               w_win;

    logic [1:0]         w_ack_nxt;
    logic               w_start_nxt;
    logic [1:0]         w_sel_nxt;
    logic [WIDTH-1:0]   w_mdata_nxt;
    logic               w_rsp_valid_nxt;
    logic               w_rsp_id_nxt;
    logic [WIDTH-1:0]   w_rsp_data_nxt;
    logic               w_rsp_fail_nxt;
    logic               w_rsp_tmo_nxt;
    logic               w_busy_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_id_nxt        = r_id;
        w_frame_nxt     = r_frame;
        w_tgt_nxt       = r_tgt;
        w_retry_nxt     = r_retry;
        w_timer_nxt     = r_timer;
        w_gap_nxt       = r_gap;
        w_win           = 1'b0;
        w_ack_nxt       = 2'b00;
        w_start_nxt     = 1'b0;
        w_sel_nxt       = m_sel;
        w_mdata_nxt     = m_data;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_id_nxt    = rsp_id;
        w_rsp_data_nxt  = rsp_data;
        w_rsp_fail_nxt  = rsp_fail;
        w_rsp_tmo_nxt   = rsp_tmo;

        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester that did not win last time goes first
                    w_win       = (req == 2'b11) ? ~r_last : req[1];
                    w_id_nxt    = w_win;
                    w_last_nxt  = w_win;
                    w_frame_nxt = w_win ? req_data1 : req_data0;
                    w_tgt_nxt   = req_tgt[w_win];
                    w_retry_nxt = '0;
                    w_ack_nxt   = w_win ? 2'b10 : 2'b01;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_start_nxt = 1'b1;
                w_sel_nxt   = r_tgt ? 2'b10 : 2'b01;
                w_mdata_nxt = r_frame;
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + 1'b1;
                if (m_done) begin
                    w_sel_nxt   = 2'b00;
                    w_mdata_nxt = '0;
                    if (m_err && (r_retry < c_max_retry)) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_id_nxt    = r_id;
                        w_rsp_data_nxt  = m_rdata;
                        w_rsp_fail_nxt  = m_err;
                        w_rsp_tmo_nxt   = 1'b0;
                        w_state_nxt     = S_RESP;
                    end
                end else if (r_timer == c_tmr_last) begin
                    w_sel_nxt       = 2'b00;
                    w_mdata_nxt     = '0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = r_id;
                    w_rsp_data_nxt  = '0;
                    w_rsp_fail_nxt  = 1'b1;
                    w_rsp_tmo_nxt   = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_GAP: begin
                w_gap_nxt = r_gap + 1'b1;
                if (r_gap == c_gap_last) begin
                    w_state_nxt = S_START;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_frame   <= '0;
            r_tgt     <= 1'b0;
            r_retry   <= '0;
            r_timer   <= '0;
            r_gap     <= '0;
            ack       <= 2'b00;
            m_start   <= 1'b0;
            m_sel     <= 2'b00;
            m_data    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_fail  <= 1'b0;
            rsp_tmo   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_id      <= w_id_nxt;
            r_frame   <= w_frame_nxt;
            r_tgt     <= w_tgt_nxt;
            r_retry   <= w_retry_nxt;
            r_timer   <= w_timer_nxt;
            r_gap     <= w_gap_nxt;
            ack       <= w_ack_nxt;
            m_start   <= w_start_nxt;
            m_sel     <= w_sel_nxt;
            m_data    <= w_mdata_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_id    <= w_rsp_id_nxt;
            rsp_data  <= w_rsp_data_nxt;
            rsp_fail  <= w_rsp_fail_nxt;
            rsp_tmo   <= w_rsp_tmo_nxt;
            busy      <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire
